partial_sum_resolver: RTL
=========================

# partial_sum_resolver

Consumes the redundant pair (r0, r1) emitted by the pipelined a×bi multiplier stage, together with an optional addend c, and resolves r0 + r1 + c into a single non-redundant binary sum. It uses a radix-wide serial carry-propagate adder, one chunk per cycle. It sits directly downstream of the multiplier: the multiplier's done pulse drives `en` here. Its `en_out` is the next stage's start strobe.

## Interface
- `Size`, default 3072: modulus width; matches the multiplier stage.
- `radix`, default 108: chunk width in bits; equals the multiplier digit width.
- Derived `W` = Size+radix+2 = 3182: operand width.
- Derived `NCHUNK` = ceil(W/radix) = 30: chunks processed.
- Derived `PW` = NCHUNK·radix = 3240: padded internal width.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low; clock `clk`.
- `en`  in  1: single-cycle start strobe; samples `r0`, `r1` and `c`.
- `r0`  in  W: low-half partial products.
- `r1`  in  W: high-half partial products, already block-shifted.
- `c`  in  W: extra addend; tie to 0 when unused.
- `sum`  out  W+2: registered result r0+r1+c.
- `busy`  out  1: high while not IDLE.
- `en_out`  out  1: one-cycle pulse; `sum` is valid from this cycle.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE, on `en`:
  - load `r0`, `r1` and `c`, each zero-extended to PW, into three operand shift registers;
  - clear the 2-bit carry `cy`;
  - clear chunk counter `idx`;
  - go to RUN.
- RUN, each cycle:
  - `t` = op0[radix-1:0] + op1[radix-1:0] + op2[radix-1:0] + `cy`, width radix+2;
  - shift the accumulator right by radix and insert `t[radix-1:0]` at the top: acc ← {t[radix-1:0], acc[PW-1:radix]};
  - `cy` ← `t[radix+1:radix]`;
  - shift all three operands right by radix;
  - increment `idx`.
  - When `idx` == NCHUNK-1, go to DONE.
- DONE:
  - `sum` ← acc[W+1:0];
  - `en_out` = 1;
  - return to IDLE.
- Width rules:
  - Carry per chunk is at most 2, so `cy` is 2 bits.
  - Operands are < 2^W, so the total is < 3·2^W and fits in W+2 bits.
  - The final `cy` out of chunk NCHUNK-1 is always 0 and is discarded.
- `en` while `busy` is ignored; it does not restart and is not queued.
- `sum` holds its last value until the next DONE.
- Operand indexing uses shift registers only. No variable part-selects on `idx`.

## Timing
- Reset values:
  - `sum` = 0, `en_out` = 0, `busy` = 0;
  - state = IDLE, `idx` = 0, `cy` = 0;
  - operand and accumulator registers = 0.
- Cycle accounting, with `en` sampled at edge 0:
  - RUN occupies cycles 1..30;
  - DONE at cycle 31, where `en_out` is high and the new `sum` is visible.
  - Latency is 31 cycles from `en` to `en_out`.
- `busy` is high in cycles 1..31 and low in IDLE.
- Back-to-back operation: `en` is accepted again in the cycle after DONE, so throughput is one result per 32 cycles.
  - `en` coincident with DONE is ignored.
- Reset mid-operation, at any state:
  - abort, go to IDLE with all reset values;
  - no `en_out` is produced.
- Simultaneous `en` and `rst_n` = 0: reset wins.

## Structure
- Shared package `inner_loop_pkg` holds:
  - derived constants W, NCHUNK, PW computed from Size and radix;
  - the FSM state encoding (IDLE, RUN, DONE), so the multiplier and downstream stages share it.
- One combinational sub-module, `chunk_add3`:
  - inputs: three radix-bit operands plus a 2-bit carry-in;
  - outputs: radix-bit sum and 2-bit carry-out.
  - It is isolated so the critical path can be retimed or DSP-mapped independently.
- The top level holds the FSM, the counter, and the shift registers.

## Test plan
- Basic: r0=1, r1=2, c=3, pulse `en` → `en_out` exactly 31 cycles later, `sum` = 6, `busy` high cycles 1..31.
- Full carry ripple: r0 = 2^W−1, r1 = 1, c = 0 → `sum` = 2^3182, i.e. `sum`[3182] = 1 and all other bits 0.
- Max operands: r0 = r1 = c = 2^W−1 → `sum` = 3·(2^W−1); bits [W+1:W] = 2'b10 and low bits = 2^W−3.
- End-to-end: random 3074-bit `a` and 108-bit `bi` through the multiplier stage, with its done pulse chained to `en` and c = 0 → `sum` == a·bi for 200 random vectors.
- Ignored start: pulse `en` again at cycles 5 and 31 → a single `en_out` at cycle 31 with the first operands' result; a new `en` at cycle 32 is accepted.
- Reset mid-run: deassert `rst_n` for one cycle at cycle 10 → no `en_out`, `sum` = 0, `busy` = 0; a following `en` completes normally in 31 cycles.

Source files
------------

// File: rtl/inner_loop_pkg.sv
// Constants and FSM encoding shared by the multiplier stage and its downstream resolver.
package inner_loop_pkg;

   localparam int SIZE_DEFAULT  = 3072;
   localparam int RADIX_DEFAULT = 108;

   function automatic int calc_w(input int size, input int radix);
      return size + radix + 2;
   endfunction

   function automatic int calc_nchunk(input int size, input int radix);
      return (calc_w(size, radix) + radix - 1) / radix;
   endfunction

   localparam int W      = calc_w(SIZE_DEFAULT, RADIX_DEFAULT);
   localparam int NCHUNK = calc_nchunk(SIZE_DEFAULT, RADIX_DEFAULT);
   localparam int PW     = NCHUNK * RADIX_DEFAULT;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/chunk_add3.sv
// Three-operand chunk adder with a 2-bit carry; kept separate so it can be retimed or DSP-mapped.
module chunk_add3 #(
   parameter int radix = 108
) (
   input  logic [radix-1:0] a,
   input  logic [radix-1:0] b,
   input  logic [radix-1:0] d,
   input  logic [1:0]       cin,
   output logic [radix-1:0] s,
   output logic [1:0]       cout
);

   logic [radix+1:0] t;

   assign t    = {2'b00, a} + {2'b00, b} + {2'b00, d} + {{radix{1'b0}}, cin};
   assign s    = t[radix-1:0];
   assign cout = t[radix+1:radix];

endmodule

// File: rtl/partial_sum_resolver.sv
// Resolves the multiplier's redundant pair plus an addend into one binary sum,
// one radix-wide chunk per cycle, least significant chunk first.
module partial_sum_resolver
   import inner_loop_pkg::*;
#(
   parameter int  Size  = 3072,
   parameter int  radix = 108,
   localparam int W     = calc_w(Size, radix)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] r0,
   input  logic [W-1:0] r1,
   input  logic [W-1:0] c,
   output logic [W+1:0] sum,
   output logic         busy,
   output logic         en_out
);

   localparam int NCHUNK = calc_nchunk(Size, radix);
   localparam int PW     = NCHUNK * radix;
   localparam int AW     = PW - radix;
   localparam int IDX_W  = $clog2(NCHUNK + 1);

   state_e           state, state_nxt;
   logic [PW-1:0]    op0, op1, op2;
   logic [AW-1:0]    acc;
   logic [1:0]       cy;
   logic [IDX_W-1:0] idx;
   logic [radix-1:0] t_sum;
   logic [1:0]       t_cy;
   logic [PW-1:0]    full;
   logic             last_chunk;

   chunk_add3 #(.radix(radix)) u_chunk_add3 (
      .a    (op0[radix-1:0]),
      .b    (op1[radix-1:0]),
      .d    (op2[radix-1:0]),
      .cin  (cy),
      .s    (t_sum),
      .cout (t_cy)
   );

   // acc holds every chunk resolved so far; the current chunk completes it.
   assign full       = {t_sum, acc};
   assign last_chunk = (idx == IDX_W'(NCHUNK - 1));
   assign busy       = (state != IDLE);
   assign en_out     = (state == DONE);

   always_comb begin
      // NOTE: defaults first, so no path through this block can infer a latch.
      state_nxt = state;
      unique case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (last_chunk) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments here so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the operand/accumulator shift registers are reset as well, so an aborted run leaves nothing stale.
         state <= IDLE;
         op0   <= '0;
         op1   <= '0;
         op2   <= '0;
         acc   <= '0;
         cy    <= '0;
         idx   <= '0;
         sum   <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (en) begin
                  op0 <= PW'(r0);
                  op1 <= PW'(r1);
                  op2 <= PW'(c);
                  cy  <= '0;
                  idx <= '0;
               end
            end
            RUN: begin
               acc <= full[PW-1:radix];
               cy  <= t_cy;
               op0 <= op0 >> radix;
               op1 <= op1 >> radix;
               op2 <= op2 >> radix;
               idx <= idx + IDX_W'(1);
               // Capture on the last chunk so the result is already visible while en_out is high.
               if (last_chunk) sum <= full[W+1:0];
            end
            default: ;
         endcase
      end
   end

endmodule
